// File: rtl/cdc_line_echo.sv
// Line echo stage: collects received bytes into a line buffer, then replays
// the whole line downstream on terminator, full buffer or idle timeout.
module cdc_line_echo #(
    parameter int unsigned DEPTH   = 64,
    parameter logic [7:0]  TERM    = 8'h0D,
    parameter bit          UPCASE  = 1'b1,
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic [15:0] line_cnt_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [23:0]   idle_q, idle_d;
    logic [15:0]   line_cnt_q, line_cnt_d;
    logic [7:0]    mem_q [DEPTH];

    logic          rx_fire;
    logic          tx_fire;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (UPCASE && (b >= 8'h61) && (b <= 8'h7A)) begin
            return b - 8'h20;
        end
        return b;
    endfunction

    assign rx_fire = (state_q == S_FILL) && rx_valid_i;
    assign tx_fire = (state_q == S_DRAIN) && tx_ready_i;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        idle_d     = idle_q;
        line_cnt_d = line_cnt_q;
        if (state_q == S_FILL) begin
            if (rx_fire) begin
                // An accepted byte always wins over a timeout expiring this cycle.
                wr_cnt_d = wr_cnt_q + 1'b1;
                idle_d   = '0;
                if ((rx_data_i == TERM) || (wr_cnt_q == CW'(DEPTH - 1))) begin
                    state_d = S_DRAIN;
                end
            end else if (wr_cnt_q != '0) begin
                idle_d = idle_q + 24'd1;
                if ((TIMEOUT != 24'd0) && (idle_d == TIMEOUT)) begin
                    state_d = S_DRAIN;
                    idle_d  = '0;
                end
            end
        end else if (tx_fire) begin
            if (rd_ptr_q == (wr_cnt_q - 1'b1)) begin
                state_d    = S_FILL;
                wr_cnt_d   = '0;
                rd_ptr_d   = '0;
                idle_d     = '0;
                line_cnt_d = line_cnt_q + 16'd1;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FILL;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            idle_q     <= '0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            idle_q     <= idle_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Line storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (rx_fire) begin
            mem_q[wr_cnt_q[AW-1:0]] <= rx_data_i;
        end
    end

    assign rx_ready_o = (state_q == S_FILL);
    assign tx_valid_o = (state_q == S_DRAIN);
    assign busy_o     = (state_q == S_DRAIN);
    assign tx_data_o  = (state_q == S_DRAIN) ? to_upper(mem_q[rd_ptr_q[AW-1:0]]) : 8'h00;
    assign line_cnt_o = line_cnt_q;

endmodule

// File: tb/tb_cdc_line_echo.sv
// Bench for cdc_line_echo: directed and random byte streams compared per cycle
// against a queue-based line model, plus explicit expected echo sequences.
module tb_cdc_line_echo;
    localparam int          DEPTH   = 4;
    localparam logic [23:0] TIMEOUT = 24'd16;
    localparam logic [7:0]  TERM    = 8'h0D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;

    logic        rx_ready, tx_valid, busy;
    logic [7:0]  tx_data;
    logic [15:0] line_cnt;
    logic        rx_ready_raw, tx_valid_raw, busy_raw;
    logic [7:0]  tx_data_raw;
    logic [15:0] line_cnt_raw;

    int errors = 0;
    int checks = 0;

    // Reference model: current line as a queue plus a replay index.
    bit          m_drain = 1'b0;
    logic [7:0]  m_line[$];
    int          m_rd = 0;
    int          m_idle = 0;
    logic [15:0] m_lcnt = 16'h0000;

    logic [7:0]  sent[$];
    logic [7:0]  sent_raw[$];

    cdc_line_echo #(.DEPTH(DEPTH), .TERM(TERM), .UPCASE(1'b1), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .busy_o(busy), .line_cnt_o(line_cnt)
    );

    cdc_line_echo #(.DEPTH(DEPTH), .TERM(TERM), .UPCASE(1'b0), .TIMEOUT(TIMEOUT)) dut_raw (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_raw),
        .tx_data_o(tx_data_raw), .tx_valid_o(tx_valid_raw), .tx_ready_i(tx_ready),
        .busy_o(busy_raw), .line_cnt_o(line_cnt_raw)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] up(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'h20) : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, drive inputs, advance the model at posedge.
    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic tr);
        logic [7:0] exp_d;
        logic [7:0] exp_raw;
        @(negedge clk);
        exp_d   = m_drain ? up(m_line[m_rd]) : 8'h00;
        exp_raw = m_drain ? m_line[m_rd] : 8'h00;
        chk("rx_ready", 32'(rx_ready), 32'(!m_drain));
        chk("tx_valid", 32'(tx_valid), 32'(m_drain));
        chk("busy", 32'(busy), 32'(m_drain));
        chk("tx_data", 32'(tx_data), 32'(exp_d));
        chk("line_cnt", 32'(line_cnt), 32'(m_lcnt));
        chk("raw_tx_valid", 32'(tx_valid_raw), 32'(m_drain));
        chk("raw_tx_data", 32'(tx_data_raw), 32'(exp_raw));
        if (tx_valid && tr) sent.push_back(tx_data);
        if (tx_valid_raw && tr) sent_raw.push_back(tx_data_raw);
        rst = r; rx_valid = v; rx_data = d; tx_ready = tr;
        @(posedge clk);
        if (r) begin
            m_drain = 1'b0; m_line.delete(); m_rd = 0; m_idle = 0; m_lcnt = 16'h0000;
        end else if (!m_drain) begin
            if (v) begin
                m_line.push_back(d);
                m_idle = 0;
                if ((d == TERM) || (m_line.size() == DEPTH)) m_drain = 1'b1;
            end else if (m_line.size() > 0) begin
                m_idle++;
                if ((TIMEOUT != 0) && (m_idle == int'(TIMEOUT))) begin
                    m_drain = 1'b1;
                    m_idle  = 0;
                end
            end
        end else if (tr) begin
            m_rd++;
            if (m_rd == m_line.size()) begin
                m_drain = 1'b0; m_line.delete(); m_rd = 0; m_idle = 0; m_lcnt++;
            end
        end
    endtask

    // Offer d until the model says it is accepted (rx_valid held high meanwhile).
    task automatic send(input logic [7:0] d, input logic tr);
        int n;
        n = 0;
        while (m_drain && (n < 100)) begin
            cyc(1'b0, 1'b1, d, 1'b1);
            n++;
        end
        chk("send_wait", 32'(m_drain), 32'd0);
        cyc(1'b0, 1'b1, d, tr);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((m_drain || (m_line.size() > 0)) && (n < max)) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("drain_done", 32'(m_drain || (m_line.size() > 0)), 32'd0);
    endtask

    task automatic chk_sent(input string tag, input int n, input logic [31:0] exp, input bit raw);
        int sz;
        sz = raw ? sent_raw.size() : sent.size();
        chk({tag, "_len"}, 32'(sz), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < sz) chk(tag, 32'(raw ? sent_raw[i] : sent[i]), 32'(exp[31-8*i -: 8]));
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        sent.delete();
        sent_raw.delete();
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m_drain = 1'b0; m_line.delete(); m_rd = 0; m_idle = 0; m_lcnt = 16'h0000;
        #2;
        chk("reset_rx_ready", 32'(rx_ready), 32'd1);
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'h00);
        chk("reset_line_cnt", 32'(line_cnt), 32'd0);

        // "ab\r" with downstream always ready
        send(8'h61, 1'b1);
        send(8'h62, 1'b1);
        send(8'h0D, 1'b1);
        #2;
        chk("ab_latency_valid", 32'(tx_valid), 32'd1);
        chk("ab_first_byte", 32'(tx_data), 32'h41);
        drain(20);
        chk_sent("ab_echo", 3, 32'h41420D00, 1'b0);
        chk_sent("ab_echo_raw", 3, 32'h61620D00, 1'b1);
        #2;
        chk("ab_line_cnt", 32'(line_cnt), 32'd1);
        chk("ab_rx_ready", 32'(rx_ready), 32'd1);

        // Six bytes into a 4-deep buffer: flush on full, remainder starts next line
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(8'h31 + 8'(i), 1'b1);
            if (i == 3) begin
                #2;
                chk("full_rx_ready_drop", 32'(rx_ready), 32'd0);
            end
        end
        #2;
        chk("full_line_cnt", 32'(line_cnt), 32'd1);
        chk_sent("full_echo", 4, 32'h31323334, 1'b0);
        sent.delete();
        drain(60);
        chk_sent("full_rest", 2, 32'h35360000, 1'b0);
        #2;
        chk("full_line_cnt2", 32'(line_cnt), 32'd2);

        // Idle timeout on a single lowercase byte
        do_reset();
        send(8'h7A, 1'b1);
        repeat (15) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        chk("timeout_not_yet", 32'(tx_valid), 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        chk("timeout_fire", 32'(tx_valid), 32'd1);
        drain(10);
        chk_sent("timeout_up", 1, 32'h5A000000, 1'b0);
        chk_sent("timeout_raw", 1, 32'h7A000000, 1'b1);

        // "x\r" with downstream ready one cycle in three and rx pressure during replay
        do_reset();
        send(8'h78, 1'b1);
        send(8'h0D, 1'b1);
        for (int k = 0; (k < 30) && m_drain; k++) begin
            cyc(1'b0, 1'b1, 8'h55, (k % 3) == 0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk_sent("stall_echo", 2, 32'h580D0000, 1'b0);
        #2;
        chk("stall_line_cnt", 32'(line_cnt), 32'd1);

        // Reset in the middle of replaying "abc\r"
        do_reset();
        send(8'h61, 1'b1);
        send(8'h62, 1'b1);
        send(8'h63, 1'b1);
        send(8'h0D, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        #2;
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
        chk("midrst_line_cnt", 32'(line_cnt), 32'd0);
        sent.delete();
        send(8'h71, 1'b1);
        send(8'h0D, 1'b1);
        drain(10);
        chk_sent("midrst_echo", 2, 32'h510D0000, 1'b0);

        // Random traffic with periodic idle stretches to exercise timeouts
        for (int i = 0; i < 800; i++) begin
            logic       v;
            logic       tr;
            logic [7:0] d;
            int         sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       d = TERM;
                1:       d = 8'h61 + 8'($urandom_range(0, 25));
                2:       d = 8'($urandom);
                default: d = 8'h41 + 8'($urandom_range(0, 25));
            endcase
            v  = (((i / 50) % 4) != 3) && ($urandom_range(0, 2) != 0);
            tr = ($urandom_range(0, 3) != 0);
            cyc(1'b0, v, d, tr);
        end
        drain(100);

        // Line counter wrap
        force dut.line_cnt_q = 16'hFFFF;
        #1;
        release dut.line_cnt_q;
        m_lcnt = 16'hFFFF;
        send(8'h0D, 1'b1);
        drain(10);
        #2;
        chk("wrap_line_cnt", 32'(line_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
